// File: rtl/trigger_seq.sv
// trigger_seq: sequences a periodic trigger generator through delay and counted-pulse bursts.
// Define TRIGGER_SEQ_REPEAT_EN to add GAP_REG/NREP_REG and the GAP state for repeated bursts.
module trigger_seq (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        go,
  input  logic        abort,
  input  logic        trig_in,
  input  logic [15:0] DELAY_REG,
  input  logic [15:0] NPULSE_REG,
  input  logic [15:0] WIDTH0_REG,
  input  logic [15:0] WIDTH1_REG,
`ifdef TRIGGER_SEQ_REPEAT_EN
  input  logic [15:0] GAP_REG,
  input  logic [7:0]  NREP_REG,
`endif
  output logic        start_out,
  output logic [15:0] width0_out,
  output logic [15:0] width1_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] pulse_cnt
);

`ifdef TRIGGER_SEQ_REPEAT_EN
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN} state_t;
`endif

  state_t      state, next;
  logic [15:0] delay_r, npulse_r, width0_r, width1_r;
  logic [15:0] cnt;
  logic        trig_d, done_r;
  logic        fall, last_fall;
`ifdef TRIGGER_SEQ_REPEAT_EN
  logic [15:0] gap_r;
  logic [7:0]  nrep_r, rep_cnt;
`endif

  assign fall      = trig_d & ~trig_in;
  assign last_fall = fall && ((pulse_cnt + 16'd1) == npulse_r);

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE:  if (go && NPULSE_REG != '0) next = S_DELAY;
      S_DELAY: if (abort) next = S_IDLE;
               else if (cnt == delay_r) next = S_RUN;
`ifdef TRIGGER_SEQ_REPEAT_EN
      S_RUN:   if (abort) next = S_IDLE;
               else if (last_fall) next = (rep_cnt != nrep_r) ? S_GAP : S_IDLE;
      S_GAP:   if (abort) next = S_IDLE;
               else if (cnt == gap_r) next = S_RUN;
`else
      S_RUN:   if (abort) next = S_IDLE;
               else if (last_fall) next = S_IDLE;
`endif
      default: next = S_IDLE;
    endcase
  end

  always_comb begin
    start_out  = (state == S_RUN);
    busy       = (state != S_IDLE);
    done       = done_r;
    width0_out = width0_r;
    width1_out = width1_r;
  end

  // Abort wins over counting: a falling edge in the abort cycle is not counted.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      delay_r   <= '0;
      npulse_r  <= '0;
      width0_r  <= '0;
      width1_r  <= '0;
      cnt       <= '0;
      pulse_cnt <= '0;
      trig_d    <= 1'b0;
      done_r    <= 1'b0;
`ifdef TRIGGER_SEQ_REPEAT_EN
      gap_r     <= '0;
      nrep_r    <= '0;
      rep_cnt   <= '0;
`endif
    end else begin
      trig_d <= trig_in;
      done_r <= 1'b0;
      case (state)
        S_IDLE: if (go) begin
          delay_r   <= DELAY_REG;
          npulse_r  <= NPULSE_REG;
          width0_r  <= WIDTH0_REG;
          width1_r  <= WIDTH1_REG;
          cnt       <= '0;
          pulse_cnt <= '0;
          if (NPULSE_REG == '0) done_r <= 1'b1;
`ifdef TRIGGER_SEQ_REPEAT_EN
          gap_r     <= GAP_REG;
          nrep_r    <= NREP_REG;
          rep_cnt   <= '0;
`endif
        end
        S_DELAY: if (!abort) cnt <= cnt + 16'd1;
        S_RUN: if (!abort && fall) begin
          pulse_cnt <= pulse_cnt + 16'd1;
          if (last_fall) begin
`ifdef TRIGGER_SEQ_REPEAT_EN
            if (rep_cnt != nrep_r) begin
              rep_cnt <= rep_cnt + 8'd1;
              cnt     <= '0;
            end else begin
              done_r  <= 1'b1;
            end
`else
            done_r <= 1'b1;
`endif
          end
        end
`ifdef TRIGGER_SEQ_REPEAT_EN
        S_GAP: if (!abort) begin
          cnt <= cnt + 16'd1;
          if (cnt == gap_r) pulse_cnt <= '0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_seq.sv
// Directed bench for trigger_seq: a scoreboard queue holds expected completion results,
// popped by a monitor on each done pulse; timing points are checked inline.
module tb_trigger_seq;

  logic        aclk = 1'b0;
  logic        aresetn, go, abort, trig_in;
  logic [15:0] DELAY_REG, NPULSE_REG, WIDTH0_REG, WIDTH1_REG;
  logic        start_out, busy, done;
  logic [15:0] width0_out, width1_out, pulse_cnt;
`ifdef TRIGGER_SEQ_REPEAT_EN
  logic [15:0] GAP_REG;
  logic [7:0]  NREP_REG;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] pcnt;
    logic [15:0] w0;
    logic [15:0] w1;
  } exp_t;
  exp_t sbq[$];

  trigger_seq dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .go         (go),
    .abort      (abort),
    .trig_in    (trig_in),
    .DELAY_REG  (DELAY_REG),
    .NPULSE_REG (NPULSE_REG),
    .WIDTH0_REG (WIDTH0_REG),
    .WIDTH1_REG (WIDTH1_REG),
`ifdef TRIGGER_SEQ_REPEAT_EN
    .GAP_REG    (GAP_REG),
    .NREP_REG   (NREP_REG),
`endif
    .start_out  (start_out),
    .width0_out (width0_out),
    .width1_out (width1_out),
    .busy       (busy),
    .done       (done),
    .pulse_cnt  (pulse_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // trig_in high for two cycles then low; the fall is counted at the following edge.
  task automatic pulse();
    trig_in = 1'b1;
    tick(2);
    trig_in = 1'b0;
    tick(1);
  endtask

  task automatic exp_push(input logic [15:0] p, input logic [15:0] w0, input logic [15:0] w1);
    exp_t e;
    e.pcnt = p;
    e.w0   = w0;
    e.w1   = w1;
    sbq.push_back(e);
  endtask

  always @(negedge aclk) begin
    if (done) begin
      exp_t e;
      chk("done_vs_busy", {15'd0, busy}, 16'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_done", 16'd1, 16'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_pulse_cnt", pulse_cnt, e.pcnt);
        chk("sb_width0", width0_out, e.w0);
        chk("sb_width1", width1_out, e.w1);
      end
    end
  end

  task automatic basic_burst(input string tag);
    DELAY_REG  = 16'd3;
    NPULSE_REG = 16'd2;
    WIDTH0_REG = 16'd5;
    WIDTH1_REG = 16'd7;
    go = 1'b1;
    exp_push(16'd2, 16'd5, 16'd7);
    tick(1);
    go = 1'b0;
    chk({tag, "_busy_T1"}, {15'd0, busy}, 16'd1);
    chk({tag, "_start_T1"}, {15'd0, start_out}, 16'd0);
    tick(3);
    chk({tag, "_start_T4"}, {15'd0, start_out}, 16'd0);
    tick(1);
    chk({tag, "_start_T5"}, {15'd0, start_out}, 16'd1);
    chk({tag, "_width0"}, width0_out, 16'd5);
    chk({tag, "_width1"}, width1_out, 16'd7);
    pulse();
    chk({tag, "_pcnt1"}, pulse_cnt, 16'd1);
    chk({tag, "_start_mid"}, {15'd0, start_out}, 16'd1);
    pulse();
    chk({tag, "_start_end"}, {15'd0, start_out}, 16'd0);
    chk({tag, "_busy_end"}, {15'd0, busy}, 16'd0);
    chk({tag, "_pcnt2"}, pulse_cnt, 16'd2);
    tick(1);
    chk({tag, "_done_one_cycle"}, {15'd0, done}, 16'd0);
  endtask

  initial begin
    aresetn = 1'b0; go = 1'b0; abort = 1'b0; trig_in = 1'b0;
    DELAY_REG = '0; NPULSE_REG = '0; WIDTH0_REG = 16'd11; WIDTH1_REG = 16'd12;
`ifdef TRIGGER_SEQ_REPEAT_EN
    GAP_REG = '0; NREP_REG = '0;
`endif
    tick(2);
    chk("rst_start", {15'd0, start_out}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_pcnt", pulse_cnt, 16'd0);
    chk("rst_width0", width0_out, 16'd0);
    aresetn = 1'b1;
    tick(1);

    basic_burst("burst");
    tick(2);

    // Zero-pulse request: done next cycle, never busy.
    NPULSE_REG = 16'd0; WIDTH0_REG = 16'd2; WIDTH1_REG = 16'd4;
    go = 1'b1;
    exp_push(16'd0, 16'd2, 16'd4);
    tick(1);
    go = 1'b0;
    chk("zero_busy", {15'd0, busy}, 16'd0);
    chk("zero_start", {15'd0, start_out}, 16'd0);
    tick(1);
    chk("zero_done_one_cycle", {15'd0, done}, 16'd0);
    chk("zero_busy2", {15'd0, busy}, 16'd0);
    tick(2);

    // Abort after one of four pulses; go and WIDTH0 changes while busy are ignored.
    DELAY_REG = 16'd0; NPULSE_REG = 16'd4; WIDTH0_REG = 16'd5; WIDTH1_REG = 16'd3;
    go = 1'b1;
    tick(1);
    go = 1'b0;
    tick(1);
    chk("abort_run_start", {15'd0, start_out}, 16'd1);
    pulse();
    chk("abort_pcnt1", pulse_cnt, 16'd1);
    WIDTH0_REG = 16'd9;
    go = 1'b1;
    tick(1);
    go = 1'b0;
    chk("busy_go_ignored", {15'd0, busy}, 16'd1);
    chk("width0_held", width0_out, 16'd5);
    chk("busy_pcnt_held", pulse_cnt, 16'd1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_start", {15'd0, start_out}, 16'd0);
    chk("abort_pcnt", pulse_cnt, 16'd1);
    chk("abort_width0", width0_out, 16'd5);
    tick(3);
    chk("abort_width0_idle", width0_out, 16'd5);

    // Next go picks up the new WIDTH0.
    NPULSE_REG = 16'd1;
    go = 1'b1;
    exp_push(16'd1, 16'd9, 16'd3);
    tick(1);
    go = 1'b0;
    chk("width0_updated", width0_out, 16'd9);
    tick(1);
    pulse();
    chk("single_end_busy", {15'd0, busy}, 16'd0);
    tick(2);

    // Reset in RUN, then a normal burst.
    DELAY_REG = 16'd3; NPULSE_REG = 16'd2; WIDTH0_REG = 16'd5; WIDTH1_REG = 16'd7;
    go = 1'b1;
    tick(1);
    go = 1'b0;
    tick(4);
    pulse();
    chk("prerst_pcnt", pulse_cnt, 16'd1);
    aresetn = 1'b0;
    tick(1);
    aresetn = 1'b1;
    chk("midrst_start", {15'd0, start_out}, 16'd0);
    chk("midrst_busy", {15'd0, busy}, 16'd0);
    chk("midrst_done", {15'd0, done}, 16'd0);
    chk("midrst_pcnt", pulse_cnt, 16'd0);
    chk("midrst_width0", width0_out, 16'd0);
    chk("midrst_width1", width1_out, 16'd0);
    tick(1);
    basic_burst("postrst");
    tick(2);

`ifdef TRIGGER_SEQ_REPEAT_EN
    // Two bursts of three pulses with a three-cycle gap, one done.
    DELAY_REG = 16'd1; NPULSE_REG = 16'd3; GAP_REG = 16'd2; NREP_REG = 8'd1;
    WIDTH0_REG = 16'd6; WIDTH1_REG = 16'd8;
    go = 1'b1;
    exp_push(16'd3, 16'd6, 16'd8);
    tick(1);
    go = 1'b0;
    tick(2);
    chk("rep_run1", {15'd0, start_out}, 16'd1);
    pulse(); pulse(); pulse();
    chk("rep_gap_start", {15'd0, start_out}, 16'd0);
    chk("rep_gap_busy", {15'd0, busy}, 16'd1);
    chk("rep_gap_pcnt", pulse_cnt, 16'd3);
    tick(2);
    chk("rep_gap_start3", {15'd0, start_out}, 16'd0);
    tick(1);
    chk("rep_run2", {15'd0, start_out}, 16'd1);
    chk("rep_run2_pcnt", pulse_cnt, 16'd0);
    pulse(); pulse(); pulse();
    chk("rep_end_busy", {15'd0, busy}, 16'd0);
    tick(2);
`endif

    chk("sb_drained", 16'(sbq.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/trigger_seq.md
TRIGGER_SEQ -- requirements
Module: trigger_seq

Interface
REQ-001 SHALL have port: aclk  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: aresetn  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port: go  in  1  burst request; sampled only in IDLE.
REQ-004 SHALL have port: abort  in  1  stop request; sampled in any non-IDLE state.
REQ-005 SHALL have port: trig_in  in  1  trigger output of the periodic trigger generator being sequenced.
REQ-006 SHALL have port: start_out  out  1  start/enable to the generator.
REQ-007 SHALL have ports: width0_out, width1_out  out  16 each  high/low widths presented to the generator.
REQ-008 SHALL have ports: busy  out  1; done  out  1  one-cycle completion pulse; pulse_cnt  out  16  falling edges counted in the current burst.
REQ-009 SHALL have register inputs: DELAY_REG, NPULSE_REG, WIDTH0_REG, WIDTH1_REG  in  16 each.

Function
REQ-010 SHALL implement states IDLE, DELAY, RUN, plus GAP when REQ-022 applies.
REQ-011 SHALL, in IDLE with go=1, latch DELAY_REG, NPULSE_REG, WIDTH0_REG and WIDTH1_REG, clear pulse_cnt, and enter DELAY next cycle; latched values SHALL hold constant until the next return to IDLE.
REQ-012 SHALL, in IDLE with go=1 and NPULSE_REG=0, stay in IDLE and pulse done for one cycle on the next cycle; no start_out.
REQ-013 SHALL remain in DELAY for delay_r+1 cycles (counter 0..delay_r), then enter RUN; delay_r=0 gives 1 cycle.
REQ-014 SHALL drive start_out=1 only while state=RUN, decoded from the state register with no combinational input-to-output path.
REQ-015 SHALL register trig_in once (trig_d); falling edge = trig_d & ~trig_in, detected only in RUN.
REQ-016 SHALL increment pulse_cnt on each falling edge in RUN; 16-bit, no wrap, since the count stops at npulse_r.
REQ-017 SHALL, on the falling edge that makes pulse_cnt equal npulse_r, leave RUN next cycle: go to IDLE with done=1 for one cycle, or to GAP per REQ-022.
REQ-018 SHALL drive busy=1 in every state except IDLE; done and busy are never both 1.
REQ-019 SHALL, on abort=1 in DELAY, RUN or GAP, return to IDLE next cycle with start_out=0 and no done pulse; pulse_cnt holds its value.
REQ-020 SHALL ignore go outside IDLE; abort has priority over every other transition in the same cycle.
REQ-021 SHALL drive width0_out/width1_out from latched registers; values update only on go acceptance.

Configuration
REQ-022 SHALL, with macro TRIGGER_SEQ_REPEAT_EN defined, add inputs GAP_REG (16 bits) and NREP_REG (8 bits), latched with the others.
- After each burst completes with a count below nrep_r+1, the block enters GAP for gap_r+1 cycles with start_out=0.
- It then clears pulse_cnt and re-enters RUN, without repeating DELAY.
- done pulses only after nrep_r+1 bursts.
REQ-023 SHALL, without TRIGGER_SEQ_REPEAT_EN, omit the GAP_REG/NREP_REG ports and the GAP state; exactly one burst per go.

Reset
REQ-024 SHALL, while aresetn=0 at a clock edge, force state=IDLE and clear outputs and internal registers.
- Outputs cleared: start_out, busy, done, pulse_cnt, width0_out, width1_out.
- Internal registers cleared: trig_d, counters, latched registers.
REQ-025 SHALL treat reset mid-burst identically to REQ-024; start_out is 0 in the first cycle after reset.

Verification
REQ-026 SHALL cover basic burst: DELAY_REG=3, NPULSE_REG=2, go at cycle T -> busy=1 from T+1, start_out=1 from T+5, start_out falls the cycle after the 2nd trig_in falling edge, done=1 for one cycle, pulse_cnt=2.
REQ-027 SHALL cover zero pulses: NPULSE_REG=0, go -> done=1 one cycle later, busy and start_out stay 0.
REQ-028 SHALL cover abort: abort during RUN after 1 of 4 pulses -> IDLE next cycle, start_out=0, no done, pulse_cnt=1; go ignored while busy=1.
REQ-029 SHALL cover register stability: change WIDTH0_REG from 5 to 9 mid-burst -> width0_out stays 5 until the next go.
REQ-030 SHALL cover repeat, with TRIGGER_SEQ_REPEAT_EN: NREP_REG=1, GAP_REG=2, NPULSE_REG=3 -> two RUN periods of 3 pulses each, separated by 3 cycles of start_out=0, one done pulse at the end.
REQ-031 SHALL cover reset in RUN: aresetn=0 for 1 cycle -> all outputs 0, state=IDLE; the next go behaves per REQ-026.
